// File: rtl/alu_operand_stack.sv
// Operand stack and sequencer in front of a purely combinational ALU.
// Services PUSH/POP commands and multi-cycle ALU operations with depth checking.
module alu_operand_stack #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic [1:0]        cmd_sl,
    input  logic [DATA_W-1:0] push_data,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [1:0]        alu_sl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err
);

    // state  | meaning
    // IDLE   | ready for a command; PUSH/POP complete here in one cycle
    // LOAD_B | pop top of stack into b_reg
    // LOAD_A | pop next entry into a_reg (binary functions only)
    // EXEC   | push alu_out back onto the stack
    typedef enum logic [1:0] {IDLE, LOAD_B, LOAD_A, EXEC} state_t;

    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_POP  = 2'b01;
    localparam logic [1:0] CMD_ALU  = 2'b10;
    localparam logic [1:0] FN_NOT   = 2'b11;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   a_reg, b_reg;
    logic                accept, reject, push_we;
    logic [ADDR_W-1:0]   top_idx, wr_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign alu_a   = a_reg;
    assign alu_b   = b_reg;
    assign top_idx = ADDR_W'(count - CNT_W'(1));
    assign wr_idx  = ADDR_W'(count);
    assign accept  = cmd_valid && cmd_ready;
    assign push_we = accept && !reject && (cmd == CMD_PUSH);

    always_comb begin
        reject = 1'b1;
        case (cmd)
            CMD_PUSH: reject = full;
            CMD_POP:  reject = empty;
            CMD_ALU:  reject = (cmd_sl == FN_NOT) ? (count < CNT_W'(1))
                                                  : (count < CNT_W'(2));
            default:  reject = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject && cmd == CMD_ALU) state_nxt = LOAD_B;
            LOAD_B:  state_nxt = (alu_sl == FN_NOT) ? EXEC : LOAD_A;
            LOAD_A:  state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            err       <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            alu_sl    <= '0;
        end else begin
            pop_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (reject) begin
                        err <= 1'b1;
                    end else begin
                        case (cmd)
                            CMD_PUSH: count <= count + CNT_W'(1);
                            CMD_POP: begin
                                pop_data  <= mem[top_idx];
                                pop_valid <= 1'b1;
                                count     <= count - CNT_W'(1);
                            end
                            CMD_ALU: begin
                                alu_sl <= cmd_sl;
                                if (cmd_sl == FN_NOT) a_reg <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD_B: begin
                    b_reg <= mem[top_idx];
                    count <= count - CNT_W'(1);
                end
                LOAD_A: begin
                    a_reg <= mem[top_idx];
                    count <= count - CNT_W'(1);
                end
                EXEC:    count <= count + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Stack RAM carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (push_we)              mem[wr_idx] <= push_data;
        else if (state == EXEC)   mem[wr_idx] <= alu_out;
    end

endmodule

// File: tb/tb_alu_operand_stack.sv
// Bench for alu_operand_stack: vector table plus pop-data scoreboard,
// with hand-written sequences for busy-hold and mid-sequence reset.
module tb_alu_operand_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [1:0] cmd_sl = 2'b00;
    logic [4:0] push_data = 5'd0;
    logic       cmd_ready, pop_valid, full, empty, err;
    logic [4:0] pop_data, alu_a, alu_b, alu_out;
    logic [1:0] alu_sl;
    logic [3:0] count;

    int n_vec = 0;
    int n_bad = 0;
    logic [4:0] sb [$];

    typedef struct {
        logic [1:0] c;
        logic [1:0] sl;
        logic [4:0] d;
        logic       e;
        int         cnt;
        int         lat;
        logic [4:0] pd;
        logic [4:0] a;
        logic [4:0] b;
    } vec_t;
    vec_t vecs [$];

    alu_operand_stack #(.DATA_W(5), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_sl(cmd_sl),
        .push_data(push_data), .cmd_ready(cmd_ready), .pop_data(pop_data),
        .pop_valid(pop_valid), .alu_sl(alu_sl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .count(count), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    // Reference ALU on the far side of the interface
    always_comb begin
        case (alu_sl)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a & alu_b;
            default: alu_out = ~alu_b;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && pop_valid) begin
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else                chk("pop_data", int'(pop_data), int'(sb.pop_front()));
        end
    end

    task automatic addv(input logic [1:0] c, input logic [1:0] sl, input logic [4:0] d,
                        input logic e, input int cnt, input int lat,
                        input logic [4:0] pd, input logic [4:0] a, input logic [4:0] b);
        vec_t v;
        v.c = c; v.sl = sl; v.d = d; v.e = e; v.cnt = cnt; v.lat = lat;
        v.pd = pd; v.a = a; v.b = b;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        cmd_valid = 1'b1; cmd = v.c; cmd_sl = v.sl; push_data = v.d;
        if (v.c == 2'b01 && !v.e) sb.push_back(v.pd);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("err", int'(err), int'(v.e));
        chk("pop_valid", int'(pop_valid), (v.c == 2'b01 && !v.e) ? 1 : 0);
        lat = 0;
        while (!cmd_ready && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("count", int'(count), v.cnt);
        chk("full", int'(full), (v.cnt == 8) ? 1 : 0);
        chk("empty", int'(empty), (v.cnt == 0) ? 1 : 0);
        if (v.c == 2'b10 && !v.e) begin
            chk("alu_a", int'(alu_a), int'(v.a));
            chk("alu_b", int'(alu_b), int'(v.b));
            chk("alu_sl", int'(alu_sl), int'(v.sl));
        end
    endtask

    task automatic simple(input logic [1:0] c, input logic [4:0] d, input logic [4:0] pd, input int cnt);
        vec_t v;
        v.c = c; v.sl = 2'b00; v.d = d; v.e = 1'b0; v.cnt = cnt; v.lat = 0;
        v.pd = pd; v.a = 5'd0; v.b = 5'd0;
        run_vec(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic add and pop
        addv(2'b00, 2'b00, 5'd3,  0, 1, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b00, 2'b00, 5'd9,  0, 2, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b10, 2'b00, 5'd0,  0, 1, 3, 5'd0,  5'd3,  5'd9);
        addv(2'b01, 2'b00, 5'd0,  0, 0, 0, 5'd12, 5'd0,  5'd0);
        // sub wrap, and, not
        addv(2'b00, 2'b00, 5'd2,  0, 1, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b00, 2'b00, 5'd5,  0, 2, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b10, 2'b01, 5'd0,  0, 1, 3, 5'd0,  5'd2,  5'd5);
        addv(2'b00, 2'b00, 5'd12, 0, 2, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b00, 2'b00, 5'd10, 0, 3, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b10, 2'b10, 5'd0,  0, 2, 3, 5'd0,  5'd12, 5'd10);
        addv(2'b10, 2'b11, 5'd0,  0, 2, 2, 5'd0,  5'd0,  5'd8);
        addv(2'b01, 2'b00, 5'd0,  0, 1, 0, 5'd23, 5'd0,  5'd0);
        addv(2'b01, 2'b00, 5'd0,  0, 0, 0, 5'd29, 5'd0,  5'd0);
        // Fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++)
            addv(2'b00, 2'b00, 5'(i), 0, i, 0, 5'd0, 5'd0, 5'd0);
        addv(2'b00, 2'b00, 5'd9,  1, 8, 0, 5'd0,  5'd0,  5'd0);
        for (int i = 8; i >= 1; i--)
            addv(2'b01, 2'b00, 5'd0, 0, i - 1, 0, 5'(i), 5'd0, 5'd0);
        addv(2'b01, 2'b00, 5'd0,  1, 0, 0, 5'd0,  5'd0,  5'd0);
        // Depth-checked ALU rejects and reserved command
        addv(2'b00, 2'b00, 5'd7,  0, 1, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b10, 2'b00, 5'd0,  1, 1, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b01, 2'b00, 5'd0,  0, 0, 0, 5'd7,  5'd0,  5'd0);
        addv(2'b10, 2'b11, 5'd0,  1, 0, 0, 5'd0,  5'd0,  5'd0);
        addv(2'b11, 2'b00, 5'd0,  1, 0, 0, 5'd0,  5'd0,  5'd0);

        #1 rst = 1'b1;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_sl", int'(alu_sl), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // PUSH held valid across a busy ALU sequence is taken exactly once
        simple(2'b00, 5'd4, 5'd0, 1);
        simple(2'b00, 5'd6, 5'd0, 2);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 2'b10; cmd_sl = 2'b00;
        @(posedge clk); #1;
        cmd = 2'b00; push_data = 5'd17;
        chk("hold_ready_busy", int'(cmd_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_count_busy", int'(count), 0);
        @(posedge clk); #1;
        chk("hold_ready_back", int'(cmd_ready), 1);
        chk("hold_count_exec", int'(count), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("hold_count_accept", int'(count), 2);
        simple(2'b01, 5'd0, 5'd17, 1);
        simple(2'b01, 5'd0, 5'd10, 0);

        // Asynchronous reset while in LOAD_A
        simple(2'b00, 5'd1, 5'd0, 1);
        simple(2'b00, 5'd2, 5'd0, 2);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = 2'b10; cmd_sl = 2'b00;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("midrst_pre_count", int'(count), 1);
        rst = 1'b1;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_pop_valid", int'(pop_valid), 0);
        chk("midrst_empty", int'(empty), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle_hold", int'(cmd_ready), 1);
        simple(2'b00, 5'd5, 5'd0, 1);
        simple(2'b01, 5'd0, 5'd5, 0);

        @(negedge clk); @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stack.md
# alu_operand_stack

Operand stack and sequencer on the requester side of the ALU in the stack-based multi-cycle processor. It holds DATA_W-bit values, and services PUSH and POP commands from the controller. For an ALU command it pops operands, drives `alu_a`/`alu_b`/`alu_sl`, captures `alu_out` and pushes the result. The ALU stays purely combinational; this block owns all operand sequencing, depth checking and write-back.

## Interface
- `DATA_W`, 5: operand/result width; must match the ALU datapath.
- `DEPTH`, 8: stack entries, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: a command is presented.
- `cmd` input 2: 00 PUSH, 01 POP, 10 ALU, 11 reserved.
- `cmd_sl` input 2: ALU function for ALU cmd: 00 add, 01 sub, 10 and, 11 not (unary).
- `push_data` input DATA_W: PUSH operand.
- `cmd_ready` output 1: block accepts a command this cycle.
- `pop_data` output DATA_W: popped value, valid with `pop_valid`.
- `pop_valid` output 1: one-cycle pulse.
- `alu_sl` output 2: function select to the ALU.
- `alu_a` output DATA_W: ALU Ain (second-from-top operand).
- `alu_b` output DATA_W: ALU Bin (top operand).
- `alu_out` input DATA_W: ALU result, combinational from `alu_a`/`alu_b`/`alu_sl`.
- `count` output clog2(DEPTH+1): current occupancy.
- `full` output 1: `count == DEPTH`. `empty` output 1: `count == 0`.
- `err` output 1: one-cycle pulse on a rejected command.

## Operation
- States: IDLE, LOAD_B, LOAD_A, EXEC. `cmd_ready` = (state == IDLE). A command is accepted when `cmd_valid && cmd_ready`.
- PUSH: write `push_data` at `mem[count]` and increment `count`. Stays in IDLE.
- POP: register `mem[count-1]` into `pop_data`, pulse `pop_valid` and decrement `count`. Stays in IDLE.
- ALU: latch `cmd_sl` into `alu_sl`, then go to LOAD_B.
  - LOAD_B: `b_reg <= mem[count-1]` and `count--`. Goes to LOAD_A if `alu_sl != 11`, otherwise to EXEC.
  - LOAD_A: `a_reg <= mem[count-1]` and `count--`. Goes to EXEC.
  - EXEC: `mem[count] <= alu_out` and `count++`. Returns to IDLE.
- `alu_a = a_reg` and `alu_b = b_reg` at all times. `a_reg` is cleared to 0 on acceptance of a unary ALU command.
- Result width is DATA_W. Add/sub wrap modulo 2^DATA_W inside the ALU; no carry or flag is kept.
- Rejection: the command is consumed with `err` pulsing for one cycle and no other state change. Rejected commands are:
  - PUSH when full;
  - POP when empty;
  - binary ALU when `count < 2`;
  - unary ALU when `count < 1`;
  - cmd 11.
- ALU never overflows: it pops ≥1 entry before pushing 1.
- `cmd_valid` while not ready is ignored; the command is neither queued nor flagged.

## Timing
- Reset (async, immediate):
  - state IDLE;
  - `count` 0, `empty` 1, `full` 0;
  - `pop_data`, `a_reg`, `b_reg` and `alu_sl` all 0;
  - `pop_valid` 0, `err` 0;
  - `cmd_ready` 1.
  - Stack RAM is not reset.
- PUSH: `count` updates on the edge that accepts it. Back-to-back PUSH/POP is allowed every cycle.
- POP: `pop_valid` and `pop_data` are high/valid in the cycle after acceptance.
- ALU binary: accept at edge 0; LOAD_B edge 1, LOAD_A edge 2, EXEC edge 3. Result is visible at top-of-stack and `count` from edge 3. `cmd_ready` is low for cycles 1–3.
- ALU unary: the result is written at edge 2.
- `err` asserts in the cycle after the rejected accept.
- Reset mid-ALU sequence aborts it: operands already popped are lost and `count` goes to 0.
- `full`, `empty` and `count` are registered-state derived with no combinational path from `cmd_valid`.

## Test plan
- Reset, then PUSH 3 and PUSH 9, then ALU `cmd_sl`=00 → `alu_a`=3 and `alu_b`=9 in EXEC; top becomes 12; `count`=1. Then POP → `pop_data`=12 with a `pop_valid` pulse; `empty`=1.
- PUSH 2, PUSH 5, ALU sub → top = 2−5 = 29 (wrap, DATA_W=5). PUSH 12, PUSH 10, ALU and → 8. ALU not on 8 → 23; binary sequence takes 3 cycles, unary 2.
- Fill to DEPTH=8 with values 1..8 → `full`=1. A ninth PUSH → `err` pulse and `count` stays 8. POP ×8 returns 8..1; then POP → `err` and `empty` stays 1.
- With `count`=1, binary ALU → `err` with stack unchanged. With `count`=0, unary ALU → `err`. cmd 11 → `err`.
- Hold `cmd_valid` high with PUSH during an ALU sequence → ignored while `cmd_ready`=0, then accepted once in IDLE.
- Assert `rst` in LOAD_A → state IDLE, `count`=0, `cmd_ready`=1, `pop_valid`=0, all immediately without waiting for a clock edge.
